// File: rtl/adder_share_pkg.sv
// Shared types and helpers for blocks that time-share the 4-input pipelined adder.
package adder_share_pkg;

   localparam int unsigned W_DEFAULT   = 16;
   localparam int unsigned OPS_PER_REQ = 4;
   // Widest requester ID supported (NUM_REQ up to 8); narrower configs use the low bits.
   localparam int unsigned ID_MAX_W    = 3;

   typedef struct packed {
      logic                valid;
      logic [ID_MAX_W-1:0] id;
   } tag_t;

   function automatic int unsigned sum_w(input int unsigned w);
      return w + 2;
   endfunction

   function automatic int unsigned op_offset(input int unsigned req, input int unsigned op,
                                             input int unsigned w);
      return (req * OPS_PER_REQ + op) * w;
   endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr (modulo NUM_REQ) wins.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDW-1:0]     ptr_i,
   output logic [NUM_REQ-1:0] gnt_c_o,
   output logic [IDW-1:0]     gnt_idx_c_o,
   output logic               any_c_o
);

   int unsigned cand;

   always_comb begin
      gnt_c_o     = '0;
      gnt_idx_c_o = '0;
      any_c_o     = 1'b0;
      cand        = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = (32'(ptr_i) + k) % NUM_REQ;
         if (!any_c_o && req_i[IDW'(cand)]) begin
            any_c_o                = 1'b1;
            gnt_c_o[IDW'(cand)]    = 1'b1;
            gnt_idx_c_o            = IDW'(cand);
         end
      end
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin front end for one shared pipelined 4-input adder; returns each sum tagged
// with the requester that issued it, one accept and at most one response per cycle.
module adder_share_arbiter
   import adder_share_pkg::*;
#(
   parameter int unsigned W       = W_DEFAULT,
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADD_LAT = 2,
   parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ*OPS_PER_REQ*W-1:0] req_ops,
   output logic [W-1:0]                   add_in1,
   output logic [W-1:0]                   add_in2,
   output logic [W-1:0]                   add_in3,
   output logic [W-1:0]                   add_in4,
   input  logic [sum_w(W)-1:0]            add_out,
   output logic                           rsp_valid,
   output logic [IDW-1:0]                 rsp_id,
   output logic [sum_w(W)-1:0]            rsp_data,
   output logic                           busy
);

   localparam int unsigned CNT_W = $clog2(ADD_LAT + 1);

   logic [NUM_REQ-1:0] gnt_c;
   logic [IDW-1:0]     gnt_idx_c;
   logic               xfer_c;

   logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   inflight_q, inflight_d;
   logic [W-1:0]       add_in_q [OPS_PER_REQ];
   logic [W-1:0]       add_in_d [OPS_PER_REQ];
   tag_t               tag_q [ADD_LAT];
   tag_t               tag_d [ADD_LAT];
   logic [W-1:0]       ops_arr [NUM_REQ][OPS_PER_REQ];
   logic               leave_c;
   logic               unused_tag_bits;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_rr_arbiter (
      .req_i       (req_valid),
      .ptr_i       (rr_ptr_q),
      .gnt_c_o     (gnt_c),
      .gnt_idx_c_o (gnt_idx_c),
      .any_c_o     (xfer_c)
   );

   // Unpack the flat operand bus into a requester x operand array.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      for (genvar gj = 0; gj < OPS_PER_REQ; gj++) begin : g_op
         assign ops_arr[gi][gj] = req_ops[op_offset(gi, gj, W) +: W];
      end
   end

   assign req_ready = rst ? '0 : gnt_c;
   assign leave_c   = tag_q[ADD_LAT-1].valid;

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      inflight_d = inflight_q;
      for (int unsigned j = 0; j < OPS_PER_REQ; j++) begin
         add_in_d[j] = '0;
      end
      tag_d[0] = '0;
      for (int unsigned i = 1; i < ADD_LAT; i++) begin
         tag_d[i] = tag_q[i-1];
      end

      if (xfer_c) begin
         for (int unsigned j = 0; j < OPS_PER_REQ; j++) begin
            add_in_d[j] = ops_arr[gnt_idx_c][j];
         end
         tag_d[0].valid = 1'b1;
         tag_d[0].id    = ID_MAX_W'(gnt_idx_c);
         rr_ptr_d       = (gnt_idx_c == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx_c + IDW'(1);
      end

      // A simultaneous accept and retire leaves the count unchanged.
      if (xfer_c && !leave_c) begin
         inflight_d = inflight_q + CNT_W'(1);
      end else if (!xfer_c && leave_c) begin
         inflight_d = inflight_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         inflight_q <= '0;
         for (int unsigned j = 0; j < OPS_PER_REQ; j++) begin
            add_in_q[j] <= '0;
         end
         for (int unsigned i = 0; i < ADD_LAT; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         inflight_q <= inflight_d;
         for (int unsigned j = 0; j < OPS_PER_REQ; j++) begin
            add_in_q[j] <= add_in_d[j];
         end
         for (int unsigned i = 0; i < ADD_LAT; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

   assign add_in1   = add_in_q[0];
   assign add_in2   = add_in_q[1];
   assign add_in3   = add_in_q[2];
   assign add_in4   = add_in_q[3];
   assign rsp_valid = tag_q[ADD_LAT-1].valid;
   assign rsp_id    = tag_q[ADD_LAT-1].id[IDW-1:0];
   assign rsp_data  = add_out;
   assign busy      = (inflight_q != '0);

   assign unused_tag_bits = ^tag_q[ADD_LAT-1].id;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter with a behavioural adder behind it.
module tb_adder_share_arbiter;

   localparam int unsigned NR  = 4;
   localparam int unsigned W   = 16;
   localparam int unsigned LAT = 2;
   localparam int unsigned SW  = W + 2;

   typedef struct {
      int unsigned   id;
      logic [SW-1:0] sum;
      int unsigned   due;
   } exp_t;

   logic              clk;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*4*W-1:0] req_ops;
   logic [W-1:0]      add_in1, add_in2, add_in3, add_in4;
   logic [SW-1:0]     add_out;
   logic              rsp_valid;
   logic [1:0]        rsp_id;
   logic [SW-1:0]     rsp_data;
   logic              busy;

   int          n_tests;
   int          n_fail;
   int unsigned cyc;
   int unsigned m_ptr;
   exp_t        sb[$];
   int          gnt_log[$];
   logic [63:0] exp_ops;

   adder_share_arbiter #(
      .W       (W),
      .NUM_REQ (NR),
      .ADD_LAT (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_ops   (req_ops),
      .add_in1   (add_in1),
      .add_in2   (add_in2),
      .add_in3   (add_in3),
      .add_in4   (add_in4),
      .add_out   (add_out),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   // Adder model: operand registers live in the DUT, so LAT-1 stages remain here.
   logic [SW-1:0] add_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) add_q <= '0;
      else     add_q <= SW'(add_in1) + SW'(add_in2) + SW'(add_in3) + SW'(add_in4);
   end
   assign add_out = add_q;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference arbiter, operand path and response scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      int          win;
      int unsigned idx;
      logic [W-1:0] o [4];
      exp_t        e;
      logic        exp_v;
      if (rst) begin
         check("rst_ready", 64'(req_ready), 64'(0));
         check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
         check("rst_busy", 64'(busy), 64'(0));
         check("rst_add_in", {add_in1, add_in2, add_in3, add_in4}, 64'(0));
         sb.delete();
         m_ptr   = 0;
         exp_ops = '0;
      end else begin
         check("add_in", {add_in1, add_in2, add_in3, add_in4}, exp_ops);
         check("busy", 64'(busy), 64'(sb.size() != 0));
         exp_v = (sb.size() != 0) && (sb[0].due == cyc);
         check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
         if (exp_v) begin
            e = sb.pop_front();
            check("rsp_id", 64'(rsp_id), 64'(e.id));
            check("rsp_data", 64'(rsp_data), 64'(e.sum));
         end
         win = -1;
         for (int k = 0; k < int'(NR); k++) begin
            idx = (m_ptr + k) % NR;
            if (win < 0 && req_valid[idx]) win = int'(idx);
         end
         check("req_ready", 64'(req_ready), (win >= 0) ? (64'(1) << win) : 64'(0));
         for (int i = 0; i < int'(NR); i++) begin
            if (req_ready[i]) gnt_log.push_back(i);
         end
         if (win >= 0) begin
            for (int j = 0; j < 4; j++) o[j] = req_ops[(win*4+j)*W +: W];
            exp_ops  = {o[0], o[1], o[2], o[3]};
            e.id  = win;
            e.sum = SW'(o[0]) + SW'(o[1]) + SW'(o[2]) + SW'(o[3]);
            e.due = cyc + LAT;
            sb.push_back(e);
            m_ptr = (win + 1) % NR;
         end else begin
            exp_ops = '0;
         end
      end
   end

   task automatic step(input logic [NR-1:0] v);
      req_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] d);
      req_ops[(r*4+0)*W +: W] = a;
      req_ops[(r*4+1)*W +: W] = b;
      req_ops[(r*4+2)*W +: W] = c;
      req_ops[(r*4+3)*W +: W] = d;
   endtask

   task automatic check_gnts(input string tag, input int n, input int exp[5]);
      check({tag, "_count"}, 64'(gnt_log.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         check(tag, 64'((gnt_log.size() > i) ? gnt_log[i] : -1), 64'(exp[i]));
      end
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      cyc       = 0;
      m_ptr     = 0;
      exp_ops   = '0;
      rst       = 1'b1;
      req_valid = '0;
      req_ops   = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // single request from requester 0
      set_ops(0, 16'd1111, 16'd1111, 16'd1111, 16'd1111);
      step(4'b0001);
      repeat (4) step(4'b0000);

      // distinct operands catch any operand-order swap
      set_ops(2, 16'h0001, 16'h0010, 16'h0100, 16'h1000);
      step(4'b0100);
      repeat (3) step(4'b0000);

      // all four held valid straight out of reset
      rst = 1'b1;
      repeat (2) step(4'b0000);
      rst = 1'b0;
      set_ops(0, 16'd1111, 16'd1111, 16'd1111, 16'd1111);
      set_ops(1, 16'd3333, 16'd3333, 16'd3333, 16'd3333);
      set_ops(2, 16'd5555, 16'd5555, 16'd5555, 16'd5555);
      set_ops(3, 16'd7777, 16'd7777, 16'd7777, 16'd7777);
      gnt_log.delete();
      repeat (5) step(4'b1111);
      repeat (3) step(4'b0000);
      check_gnts("gnt_all4", 5, '{0, 1, 2, 3, 0});

      // pointer at 2 with requesters 0 and 3 valid
      step(4'b0010);
      gnt_log.delete();
      step(4'b1001);
      step(4'b0001);
      repeat (3) step(4'b0000);
      check_gnts("gnt_wrap", 2, '{3, 0, 0, 0, 0});

      // full-scale operands
      set_ops(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      step(4'b0010);
      repeat (3) step(4'b0000);

      // requester 2 withdraws while requester 1 is granted
      step(4'b0001);
      gnt_log.delete();
      step(4'b0110);
      step(4'b0000);
      repeat (3) step(4'b0000);
      check_gnts("gnt_withdraw", 1, '{1, 0, 0, 0, 0});

      // reset with a request still in flight
      step(4'b1000);
      step(4'b0100);
      step(4'b0000);
      rst = 1'b1;
      repeat (2) step(4'b0000);
      rst = 1'b0;
      repeat (3) step(4'b0000);
      gnt_log.delete();
      step(4'b1001);
      repeat (3) step(4'b0000);
      check_gnts("gnt_after_rst", 1, '{0, 0, 0, 0, 0});

      check("sb_drained", 64'(sb.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
